uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, byte capacity of the transmit buffer.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port data_in  input  8  byte to transmit.
REQ-007 SHALL have port valid_in  input  1  data_in valid.
REQ-008 SHALL have port ready_out  output  1  buffer can accept; byte accepted on an edge where valid_in && ready_out.
REQ-009 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high, registered.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line or the buffer is non-empty.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in the buffer, excluding the byte in the shift register.

Function
REQ-013 Bit period DIV SHALL be CLOCK_FREQ/BAUD_RATE with integer truncation (868 at defaults); every start, data and stop bit SHALL last exactly DIV clk cycles.
REQ-014 Buffer SHALL be a FIFO_DEPTH-entry circular buffer; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 ready_out SHALL equal (fifo_count != FIFO_DEPTH), with no same-cycle bypass when full, even if a pop occurs on that edge.
REQ-016 Simultaneous push and pop SHALL leave fifo_count unchanged and lose no data.
REQ-017 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-018 IDLE: tx=1; if fifo_count != 0, pop one byte into the shift register, load the bit counter with DIV-1, and go to START.
REQ-019 START: tx=0 for DIV cycles, then go to DATA with bit index 0.
REQ-020 DATA: tx=shift[index] for DIV cycles each, index 0..7, then go to STOP.
REQ-021 STOP: tx=1 for DIV cycles, pulse tx_done on the final cycle, then go to IDLE.
REQ-022 If the buffer is non-empty when STOP ends, the next frame SHALL still pass through IDLE for exactly one cycle, with tx=1, giving a total frame pitch of 10*DIV+1 cycles.
REQ-023 Latency: a byte accepted on edge N into an empty buffer with the FSM in IDLE SHALL drive tx low from edge N+2.
REQ-024 Bytes SHALL be transmitted in acceptance order; valid_in while ready_out=0 SHALL have no effect.

Reset
REQ-025 On rst, at the next edge: tx=1, ready_out=1, busy=0, tx_done=0, fifo_count=0, pointers=0, FSM=IDLE, shift register and counters=0.
REQ-026 rst mid-frame SHALL abandon the frame with tx high on the following cycle, discard all buffered bytes, and accept no byte on that edge.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef, the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1) and a function computing DIV.
REQ-028 The FIFO SHALL be a sub-module named uart_tx_buffer (clk, rst, push, pop, din, dout, count, full, empty); the FSM and baud counter SHALL be in the top module.

Verification
REQ-029 Benches SHALL use CLOCK_FREQ=1000 and BAUD_RATE=100 (DIV=10) unless stated otherwise.
REQ-030 Push 0x55 once -> tx = 0, then 1,0,1,0,1,0,1,0, then 1, each held 10 cycles; tx_done pulses once at cycle 100 of the frame; busy falls the cycle after.
REQ-031 Push 0xA5 then 0x3C back-to-back -> two correct frames, the second start bit 101 cycles after the first; fifo_count peaks at 1.
REQ-032 Hold valid_in high with 20 incrementing bytes 0x00..0x13 -> ready_out drops after 17 accepts, fifo_count=16; all 20 bytes are received in order by a monitor UART.
REQ-033 Assert rst at cycle 45 of a frame with 5 bytes queued -> tx=1 next cycle, fifo_count=0, no further frames, and no tx_done pulse.
REQ-034 At defaults, push 0xFF -> each bit lasts 868 cycles; total frame is 8680 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter.
// State encoding, frame constants and bit-period helper.
package uart_tx_fifo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffer.sv
// Byte-wide circular FIFO feeding the UART shift register.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_tx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = (count == CAP);
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd) begin
        count <= count + 1'b1;
      end else if (rd && !wr) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO plus baud-timed frame FSM.
// tx, busy and tx_done are registered one cycle behind the state.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV      = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int STOP_LEN = DIV * STOP_BITS;
  localparam int CW       = $clog2(STOP_LEN + 1);
  localparam int IW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic [7:0]           dout;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign ready_out = !full;
  assign push      = valid_in && !full && !rst;
  assign pop       = (state == ST_IDLE) && !empty && !rst;

  uart_tx_buffer #(
    .DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (data_in),
    .dout (dout),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      busy    <= (state != ST_IDLE) || !empty;
      unique case (1'b1)
        (state == ST_IDLE): begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= dout;
            cnt   <= BIT_LAST;
            state <= ST_START;
          end
        end
        (state == ST_START): begin
          tx <= 1'b0;
          if (cnt == '0) begin
            cnt   <= BIT_LAST;
            idx   <= '0;
            state <= ST_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == ST_DATA): begin
          tx <= shift[idx];
          if (cnt == '0) begin
            if (idx == IDX_LAST) begin
              cnt   <= STOP_LAST;
              state <= ST_STOP;
            end else begin
              cnt <= BIT_LAST;
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == ST_STOP): begin
          tx <= 1'b1;
          if (cnt == '0) begin
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIV=10, plus one
// default-parameter instance for the 868-cycle bit period.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  logic       rst2 = 1'b1;
  logic [7:0] data2 = 8'h00;
  logic       valid2 = 1'b0;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic       done2;
  logic [4:0] count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int maxcnt = 0;
  logic [7:0] q[$];

  uart_tx_fifo #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  uart_tx_fifo u_def (
    .clk       (clk),
    .rst       (rst2),
    .data_in   (data2),
    .valid_in  (valid2),
    .ready_out (ready2),
    .tx        (tx2),
    .busy      (busy2),
    .tx_done   (done2),
    .fifo_count(count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Line level at frame cycle k (1-based): start, 8 data bits, stop.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bi;
    bi = (k - 1) / 10;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic frame_check(input logic [7:0] b, input logic more);
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("tx_bit", tx, exp_tx(b, k));
      chk("tx_done", tx_done, k == 100);
      chk("busy_frame", busy, 1);
      if (int'(fifo_count) > maxcnt) maxcnt = fifo_count;
    end
    tick();
    chk("tx_gap", tx, 1);
    chk("tx_done_gap", tx_done, 0);
    chk("busy_after", busy, more);
  endtask

  task automatic rx_frame(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (tx !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("rx_wait", n < 2000, 1);
    if (n < 2000) begin
      repeat (4) tick();
      chk("rx_start", tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (10) tick();
        b[i] = tx;
      end
      repeat (10) tick();
      chk("rx_stop", tx, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    int s;
    int bad_line;

    // reset state
    rst = 1'b1;
    rst2 = 1'b1;
    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    rst2 = 1'b0;
    tick();

    // single 0x55 frame with exact cycle timing
    data_in = 8'h55;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("push_count", fifo_count, 1);
    tick();
    chk("lat_tx_high", tx, 1);
    chk("lat_count", fifo_count, 0);
    frame_check(8'h55, 1'b0);

    // back-to-back 0xA5, 0x3C
    maxcnt = 0;
    data_in = 8'hA5;
    valid_in = 1'b1;
    tick();
    if (int'(fifo_count) > maxcnt) maxcnt = fifo_count;
    data_in = 8'h3C;
    tick();
    if (int'(fifo_count) > maxcnt) maxcnt = fifo_count;
    valid_in = 1'b0;
    frame_check(8'hA5, 1'b1);
    frame_check(8'h3C, 1'b0);
    chk("peak_count", maxcnt, 1);

    // 20 incrementing bytes with valid held high
    fork
      begin
        int acc;
        int guard;
        logic pre;
        acc = 0;
        guard = 0;
        valid_in = 1'b1;
        while (acc < 20 && guard < 5000) begin
          data_in = acc[7:0];
          pre = ready_out;
          tick();
          guard++;
          if (pre) begin
            acc++;
            if (acc == 17) begin
              chk("full_ready", ready_out, 0);
              chk("full_count", fifo_count, 16);
            end
          end
        end
        valid_in = 1'b0;
        chk("stream_accepts", acc, 20);
      end
      begin
        logic [7:0] rb;
        for (int i = 0; i < 20; i++) begin
          rx_frame(rb);
          chk("stream_byte", rb, i);
        end
      end
    join
    wait_idle();

    // random traffic against a queue model
    q.delete();
    fork
      begin
        int sent;
        int guard;
        logic acc;
        sent = 0;
        guard = 0;
        while (sent < 12 && guard < 5000) begin
          valid_in = 1'($urandom_range(0, 1));
          data_in = 8'($urandom);
          acc = valid_in && ready_out;
          tick();
          guard++;
          if (acc) begin
            q.push_back(data_in);
            sent++;
          end
        end
        valid_in = 1'b0;
      end
      begin
        logic [7:0] rb;
        for (int i = 0; i < 12; i++) begin
          rx_frame(rb);
          if (q.size() > 0) chk("rand_byte", rb, q.pop_front());
          else chk("rand_byte", rb, 32'h100);
        end
      end
    join
    wait_idle();

    // reset mid-frame with 5 bytes queued
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(8'h40 + i);
      tick();
    end
    valid_in = 1'b0;
    chk("queued5", fifo_count, 5);
    repeat (41) tick();
    chk("mid_frame_busy", busy, 1);
    rst = 1'b1;
    valid_in = 1'b1;
    data_in = 8'h99;
    tick();
    chk("mrst_tx", tx, 1);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", tx_done, 0);
    chk("mrst_ready", ready_out, 1);
    rst = 1'b0;
    valid_in = 1'b0;
    bad_line = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0)
        bad_line++;
    end
    chk("no_frames_after_rst", bad_line, 0);
    chk("count_after_rst", fifo_count, 0);

    // default parameters: 0xFF, 868-cycle bits
    data2 = 8'hFF;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    n = 0;
    while (tx2 !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("def_start_seen", n < 100, 1);
    s = cyc;
    n = 0;
    while (tx2 === 1'b0 && n < 2000) begin
      n++;
      tick();
    end
    chk("def_start_len", n, 868);
    n = 0;
    while (done2 !== 1'b1 && n < 10000) begin
      tick();
      n++;
    end
    chk("def_frame_len", cyc - s + 1, 8680);
    tick();
    chk("def_done_pulse", done2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
